// File: rtl/top.sv
// NEC infrared remote receiver: decodes 32-bit pulse-distance frames from an active-low
// demodulated input and shows the low 24 bits on a 6-digit multiplexed common-anode display.
module top #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ir_rxb,
  output logic [5:0] o_seg_enb,
  output logic       o_seg_dp,
  output logic [6:0] o_seg
);

  function automatic longint us_to_clk(input longint us);
    return (longint'(CLK_HZ) * us) / 64'd1_000_000;
  endfunction

  // Wide enough for 20 ms, comfortably above every threshold below.
  localparam int CNT_W = $clog2(CLK_HZ / 100 + 1) + 1;
  localparam int SC_W  = $clog2(SCAN_DIV + 1);

  localparam logic [CNT_W-1:0] LEAD_L_MIN = CNT_W'(us_to_clk(8000));
  localparam logic [CNT_W-1:0] LEAD_H_MIN = CNT_W'(us_to_clk(4000));
  localparam logic [CNT_W-1:0] LEAD_H_MAX = CNT_W'(us_to_clk(5000));
  localparam logic [CNT_W-1:0] REP_H_MIN  = CNT_W'(us_to_clk(2000));
  localparam logic [CNT_W-1:0] REP_H_MAX  = CNT_W'(us_to_clk(2500));
  localparam logic [CNT_W-1:0] BIT_L_MIN  = CNT_W'(us_to_clk(400));
  localparam logic [CNT_W-1:0] BIT_L_MAX  = CNT_W'(us_to_clk(800));
  localparam logic [CNT_W-1:0] BIT_H0_MIN = CNT_W'(us_to_clk(400));
  localparam logic [CNT_W-1:0] BIT1_TH    = CNT_W'(us_to_clk(1125));
  localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(us_to_clk(3000));
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [2:0] {IDLE, LEAD_L, LEAD_H, BIT_L, BIT_H} state_e;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic             rise, fall;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [31:0]      shift_q, shift_d;
  logic [31:0]      data_q, data_d;
  logic             done_q, done_d;
  logic [SC_W-1:0]  scan_cnt_q;
  logic [2:0]       digit_q;
  logic [5:0]       seg_enb_q;
  logic [6:0]       seg_q;

  // Synchronizer idles high so a low input held during reset is not seen until release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_ir_rxb;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rise = ~rx_prev_q & rx_sync_q;
  assign fall = rx_prev_q & ~rx_sync_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    if (done_q) begin
      data_d  = shift_q;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   if (!rx_sync_q) state_d = LEAD_L;
        LEAD_L: if (rise) state_d = (cnt_q >= LEAD_L_MIN) ? LEAD_H : IDLE;
        LEAD_H: begin
          // A repeat-code space (REP_H window) also returns to IDLE, leaving data untouched.
          if (fall) begin
            if (cnt_q >= LEAD_H_MIN && cnt_q <= LEAD_H_MAX) begin
              state_d   = BIT_L;
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else if (cnt_q > LEAD_H_MAX) begin
            // The leader space is longer than the generic timeout, so give up past its window.
            state_d = IDLE;
          end
        end
        BIT_L:  if (rise) state_d = (cnt_q >= BIT_L_MIN && cnt_q <= BIT_L_MAX) ? BIT_H : IDLE;
        BIT_H: begin
          if (fall) begin
            if (cnt_q < BIT_H0_MIN) begin
              state_d = IDLE;
            end else begin
              state_d = BIT_L;
              if (cnt_q < BIT1_TH) begin
                shift_d   = {shift_q[30:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 6'd1;
                done_d    = (bit_cnt_q == 6'd31);
              end
            end
          end else if (cnt_q == BIT1_TH) begin
            // A '1' is resolved here so the final bit never depends on the stop pulse.
            shift_d   = {shift_q[30:0], 1'b1};
            bit_cnt_d = bit_cnt_q + 6'd1;
            done_d    = (bit_cnt_q == 6'd31);
          end else if (cnt_q > TIMEOUT) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h40;  4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;  4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;  4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;  4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;  4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;  4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;  4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;  default: hex_font = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      digit_q    <= '0;
      seg_enb_q  <= 6'b111110;
      seg_q      <= 7'b1000000;
    end else begin
      if (scan_cnt_q == SC_W'(SCAN_DIV - 1)) begin
        scan_cnt_q <= '0;
        digit_q    <= (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + SC_W'(1);
      end
      seg_enb_q <= ~(6'b000001 << digit_q);
      seg_q     <= hex_font(data_q[{digit_q, 2'b00} +: 4]);
    end
  end

  assign o_seg_enb = seg_enb_q;
  assign o_seg     = seg_q;
  assign o_seg_dp  = 1'b1;

endmodule

// File: tb/tb_top.sv
// Directed bench for the NEC receiver: time-scaled clock, table of frame vectors checked on the display.
module tb_top;
  localparam int CLK_HZ   = 50_000;   // 50 clocks per ms
  localparam int SCAN_DIV = 8;
  localparam int T_LEAD_L = 450, T_LEAD_H = 225, T_REP_H = 112;
  localparam int T_MARK = 28, T_SP0 = 28, T_SP1 = 84, T_BAD = 75;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ir = 1'b1;
  logic [5:0] seg_enb;
  logic       seg_dp;
  logic [6:0] seg;

  top #(.CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .i_ir_rxb(ir),
    .o_seg_enb(seg_enb), .o_seg_dp(seg_dp), .o_seg(seg)
  );

  always #5 clk = ~clk;

  typedef enum {K_FRAME, K_SHORT, K_REPEAT, K_BADBIT, K_RSTMID} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] payload;
    logic [23:0] exp_disp;
  } vec_t;

  vec_t       vecs[8];
  logic [6:0] font[16];
  int         n_vec = 0;
  int         n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic hold(input logic lvl, input int cycles);
    ir = lvl;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int low_len);
    hold(1'b0, low_len);
    hold(1'b1, b ? T_SP1 : T_SP0);
  endtask

  // Sends bits [31-first .. 31-last] of the payload; bad_idx stretches one mark to 1.5 ms.
  task automatic send_bits(input logic [31:0] p, input int first, input int last, input int bad_idx);
    for (int i = first; i <= last; i++)
      send_bit(p[31-i], (i == bad_idx) ? T_BAD : T_MARK);
  endtask

  task automatic send_stop();
    hold(1'b0, T_MARK);
    hold(1'b1, 150);
  endtask

  task automatic send_frame(input logic [31:0] p, input int bad_idx);
    hold(1'b0, T_LEAD_L);
    hold(1'b1, T_LEAD_H);
    send_bits(p, 0, 31, bad_idx);
    send_stop();
  endtask

  task automatic check_display(input logic [23:0] exp24, input string tag);
    logic [5:0] want;
    logic [3:0] nib;
    int         waited;
    for (int i = 0; i < 6; i++) begin
      want   = ~(6'b000001 << i);
      waited = 0;
      while (seg_enb !== want && waited < 8 * SCAN_DIV) begin
        @(negedge clk);
        waited++;
      end
      if (seg_enb !== want) begin
        check($sformatf("%s digit%0d enable timeout", tag, i), {26'd0, seg_enb}, {26'd0, want});
      end else begin
        nib = exp24[4*i +: 4];
        check($sformatf("%s digit%0d seg", tag, i), {25'd0, seg}, {25'd0, font[nib]});
      end
    end
  endtask

  initial begin
    logic [5:0] prev, want;
    int         gap;
    font = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{K_SHORT,  32'h0000_0000, 24'h000000};
    vecs[1] = '{K_FRAME,  32'h1234_5678, 24'h345678};
    vecs[2] = '{K_REPEAT, 32'h0000_0000, 24'h345678};
    vecs[3] = '{K_BADBIT, 32'hDEAD_BEEF, 24'h345678};
    vecs[4] = '{K_FRAME,  32'hA5C3_E1F0, 24'hC3E1F0};
    vecs[5] = '{K_FRAME,  32'h00FF_9A6B, 24'hFF9A6B};
    vecs[6] = '{K_RSTMID, 32'hCAFE_BABE, 24'h000000};
    vecs[7] = '{K_FRAME,  32'h0089_ABCD, 24'h89ABCD};

    // Reset state, then digit scan cadence.
    repeat (5) @(negedge clk);
    check("reset seg_enb", {26'd0, seg_enb}, 32'h3E);
    check("reset seg", {25'd0, seg}, 32'h40);
    check("reset dp", {31'd0, seg_dp}, 32'd1);
    rst_n = 1'b1;
    prev = seg_enb;
    for (int k = 1; k <= 7; k++) begin
      want = ~(6'b000001 << (k % 6));
      gap  = 0;
      while (seg_enb === prev && gap < 4 * SCAN_DIV) begin
        @(negedge clk);
        gap++;
      end
      check($sformatf("scan step%0d enable", k), {26'd0, seg_enb}, {26'd0, want});
      if (k > 1) check($sformatf("scan step%0d interval", k), gap, SCAN_DIV);
      prev = seg_enb;
    end

    for (int v = 0; v < 8; v++) begin
      case (vecs[v].kind)
        K_FRAME:  send_frame(vecs[v].payload, -1);
        K_BADBIT: send_frame(vecs[v].payload, 5);
        K_SHORT: begin
          hold(1'b0, 250);
          hold(1'b1, 300);
        end
        K_REPEAT: begin
          hold(1'b0, T_LEAD_L);
          hold(1'b1, T_REP_H);
          send_stop();
        end
        K_RSTMID: begin
          hold(1'b0, T_LEAD_L);
          hold(1'b1, T_LEAD_H);
          send_bits(vecs[v].payload, 0, 10, -1);
          rst_n = 1'b0;
          repeat (3) @(negedge clk);
          rst_n = 1'b1;
          send_bits(vecs[v].payload, 11, 31, -1);
          send_stop();
        end
        default: ;
      endcase
      check_display(vecs[v].exp_disp, $sformatf("vec%0d", v));
    end

    // Input already low across reset: leader is timed from release.
    ir = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b0, T_LEAD_L);
    hold(1'b1, T_LEAD_H);
    send_bits(32'h530F_0001, 0, 31, -1);
    hold(1'b1, 80);
    check_display(24'h0F0001, "lowreset");
    check("dp after frames", {31'd0, seg_dp}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
